cle_label_stat: RTL and testbench
=================================

Name: cle_label_stat

Overview:
- Post-processing reader for the component labeling engine's result SRAM (1024x8, one byte per pixel of a 32x32 image, address = row*32+col).
- After the CLE asserts finish, this block scans the SRAM once in raster order.
- Per distinct non-zero label, it accumulates pixel count and bounding box, then streams one record per label over a valid/ready interface.
- It shares the SRAM read port with the CLE and is the reader for the CLE's writer.

Parameters:
- MAX_LABELS, 8: number of label table entries; distinct labels beyond this are dropped and flagged.
- IMG_DIM, 32: image side length in pixels; the SRAM depth is IMG_DIM*IMG_DIM.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a scan; honoured only in IDLE or DONE
- sram_q  input  8  SRAM read data, valid one cycle after the address edge
- sram_a  output  10  SRAM address
- sram_wen  output  1  SRAM write enable, active-low; tied 1 (read-only)
- stat_valid  output  1  record available
- stat_ready  input  1  consumer accepts record
- stat_label  output  8  label value
- stat_count  output  11  pixel count, 1..1024
- stat_row_min, stat_row_max, stat_col_min, stat_col_max  output  5 each  bounding box
- overflow  output  1  more than MAX_LABELS distinct labels were seen
- done  output  1  level; all records emitted

Behaviour:
- Reset values: all outputs 0 except sram_wen=1; state IDLE; table cleared.
- Reset may assert in any state and returns the block to IDLE immediately.
- States: IDLE, SCAN, DRAIN, EMIT, DONE.
- IDLE/DONE + start (sampled at edge T): clear table, overflow and done; enter SCAN at T+1.
- SCAN: sram_a = scan counter 0..1023, one address per cycle; leave after issuing address 1023 (cycles T+1..T+1024).
- DRAIN: one cycle (T+1025) to process the last read word; sram_a holds 1023.
- Read pipeline: a registered copy of the issued address (row/col) travels with each read; the data process in the cycle after issue uses that row/col.
- Per-pixel rule, q = sram_q:
  - q == 0: ignored (background).
  - q matches a valid entry: count += 1; row_min/row_max/col_min/col_max updated with min/max.
  - No match and a free entry exists: allocate the next entry in first-appearance order, with count=1 and all bounds set to this pixel.
  - No match and table full: set overflow (sticky until the next start); pixel dropped.
- Matching is combinational against entries written on earlier edges, so back-to-back pixels of a new label hit the entry allocated in the previous cycle.
- EMIT (first cycle T+1026):
  - Present entry k (k from 0); stat_valid=1 and stat_* fields stable while stat_valid && !stat_ready.
  - On stat_valid && stat_ready: k += 1; the next entry is presented the following cycle with no bubble.
  - After the last accepted entry: go to DONE, stat_valid=0, done=1.
  - Zero labels: EMIT lasts one cycle with stat_valid=0, then DONE.
- DONE: done held 1 until the next start or reset; start in SCAN/DRAIN/EMIT is ignored.
- Count saturates are unnecessary: 11 bits covers 1024.
- Bounds use unsigned 5-bit compares.

Decomposition:
- Package cle_stat_pkg:
  - IMG_DIM, ADDR_W=10, CNT_W=11, POS_W=5 constants.
  - State enum.
  - Entry struct {valid, label[7:0], count[10:0], row_min, row_max, col_min, col_max}.
- One sub-module, cle_label_table:
  - MAX_LABELS entries, match/allocate/update logic.
  - Read port for EMIT by index.
  - Top level holds the FSM, address counter, read pipeline register and output handshake.

Test Plan:
- All-zero SRAM, start -> first stat_valid never asserts; done=1 at T+1027; overflow=0; sram_wen=1 throughout.
- Single label 0x05 at a 3x4 block, rows 2..4, cols 7..10 -> one record {0x05, 12, row 2..4, col 7..10}, then done.
- Labels 0x09 at addr 0 and 0x03 at addr 1023, stat_ready=1 -> records in order {0x09,1,0,0,0,0}, {0x03,1,31,31,31,31}; exercises the DRAIN path.
- Nine distinct labels on one row 0, cols 0..8 -> eight records for labels at cols 0..7, overflow=1.
- Backpressure: 3 labels, stat_ready toggling 0,0,1,0,1,1 -> each record held stable while stalled; exactly 3 transfers; done after the third.
- Reset mid-SCAN at address 500 -> all outputs return to reset values; a subsequent start gives results identical to a clean run; start pulsed during EMIT is ignored.

Source files
------------

// File: rtl/cle_stat_pkg.sv
// Shared constants, FSM state encoding and label table entry layout for the
// component-label statistics reader.
package cle_stat_pkg;

  localparam int IMG_DIM = 32;
  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 11;
  localparam int POS_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [7:0]       label;
    logic [CNT_W-1:0] count;
    logic [POS_W-1:0] row_min;
    logic [POS_W-1:0] row_max;
    logic [POS_W-1:0] col_min;
    logic [POS_W-1:0] col_max;
  } entry_t;

  function automatic logic [POS_W-1:0] pos_min(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [POS_W-1:0] pos_max(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cle_label_table.sv
// Label statistics table: matches each incoming pixel label against the stored
// entries, updates count/bounding box on a hit, allocates entries in order of
// first appearance, and reports pixels dropped because the table is full.
module cle_label_table
  import cle_stat_pkg::*;
#(
  parameter int MAX_LABELS = 8,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_pix_valid,
  input  logic [7:0]       i_label,
  input  logic [POS_W-1:0] i_row,
  input  logic [POS_W-1:0] i_col,
  input  logic [IDX_W-1:0] i_rd_idx,
  output entry_t           o_rd_entry,
  output logic [IDX_W-1:0] o_num,
  output logic             o_drop
);

  localparam int ENT_W = $bits(entry_t);

  entry_t                  r_tab [MAX_LABELS];
  logic [IDX_W-1:0]        r_num;
  logic [MAX_LABELS-1:0]   w_match;
  logic                    w_hit;
  logic [IDX_W-1:0]        w_hit_idx;
  logic                    w_active;
  logic                    w_full;
  logic                    w_alloc;
  logic [ENT_W-1:0]        w_rd_flat;

  assign w_active = i_pix_valid && (i_label != 8'd0);
  assign w_full   = (r_num == IDX_W'(MAX_LABELS));
  assign w_hit    = |w_match;
  assign w_alloc  = w_active && !w_hit && !w_full;
  assign o_drop   = w_active && !w_hit && w_full;
  assign o_num    = r_num;

  // Compare the pixel label against every stored entry; labels are unique so at most one hits.
  always_comb begin
    w_match   = '0;
    w_hit_idx = '0;
    for (int i = 0; i < MAX_LABELS; i++) begin
      w_match[i] = r_tab[i].valid && (r_tab[i].label == i_label);
      w_hit_idx  = w_hit_idx | ({IDX_W{w_match[i]}} & IDX_W'(i));
    end
  end

  // Read port used while emitting records: one-hot select of entry i_rd_idx.
  always_comb begin
    w_rd_flat = '0;
    for (int i = 0; i < MAX_LABELS; i++) begin
      w_rd_flat = w_rd_flat | ({ENT_W{i_rd_idx == IDX_W'(i)}} & ENT_W'(r_tab[i]));
    end
    o_rd_entry = entry_t'(w_rd_flat);
  end

  // Table state: clear on a new scan, update the hit entry or allocate the next free one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num <= '0;
      for (int i = 0; i < MAX_LABELS; i++) begin
        r_tab[i] <= '0;
      end
    end else if (i_clear) begin
      r_num <= '0;
      for (int i = 0; i < MAX_LABELS; i++) begin
        r_tab[i] <= '0;
      end
    end else begin
      if (w_alloc) begin
        r_num <= r_num + IDX_W'(1);
      end
      for (int i = 0; i < MAX_LABELS; i++) begin
        if (w_active && w_match[i]) begin
          r_tab[i].count   <= r_tab[i].count + CNT_W'(1);
          r_tab[i].row_min <= pos_min(r_tab[i].row_min, i_row);
          r_tab[i].row_max <= pos_max(r_tab[i].row_max, i_row);
          r_tab[i].col_min <= pos_min(r_tab[i].col_min, i_col);
          r_tab[i].col_max <= pos_max(r_tab[i].col_max, i_col);
        end else if (w_alloc && (r_num == IDX_W'(i))) begin
          r_tab[i].valid   <= 1'b1;
          r_tab[i].label   <= i_label;
          r_tab[i].count   <= CNT_W'(1);
          r_tab[i].row_min <= i_row;
          r_tab[i].row_max <= i_row;
          r_tab[i].col_min <= i_col;
          r_tab[i].col_max <= i_col;
        end
      end
    end
  end

endmodule

// File: rtl/cle_label_stat.sv
// Scans the labeling result SRAM once in raster order after start, builds a
// per-label pixel count and bounding box, then streams one record per label
// over a valid/ready interface.
module cle_label_stat
  import cle_stat_pkg::*;
#(
  parameter int MAX_LABELS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        sram_q,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_wen,
  output logic              stat_valid,
  input  logic              stat_ready,
  output logic [7:0]        stat_label,
  output logic [CNT_W-1:0]  stat_count,
  output logic [POS_W-1:0]  stat_row_min,
  output logic [POS_W-1:0]  stat_row_max,
  output logic [POS_W-1:0]  stat_col_min,
  output logic [POS_W-1:0]  stat_col_max,
  output logic              overflow,
  output logic              done
);

  localparam int                IDX_W     = $clog2(MAX_LABELS + 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_DIM * IMG_DIM - 1);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [IDX_W-1:0]  r_idx;
  logic              r_overflow;
  logic              r_done;
  logic              w_start_ok;
  logic              w_stat_valid;
  logic              w_last;
  logic              w_drop;
  logic [IDX_W-1:0]  w_num;
  entry_t            w_entry;

  assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_stat_valid = (r_state == ST_EMIT) && w_entry.valid;
  assign w_last       = ((r_idx + IDX_W'(1)) == w_num);

  cle_label_table #(
    .MAX_LABELS (MAX_LABELS),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start_ok),
    .i_pix_valid (r_rd_valid),
    .i_label     (sram_q),
    .i_row       (r_rd_addr[ADDR_W-1:POS_W]),
    .i_col       (r_rd_addr[POS_W-1:0]),
    .i_rd_idx    (r_idx),
    .o_rd_entry  (w_entry),
    .o_num       (w_num),
    .o_drop      (w_drop)
  );

  // Next-state decode for the scan / drain / emit sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SCAN; else w_next = ST_IDLE;
      ST_SCAN:  if (r_addr == ADDR_LAST) w_next = ST_DRAIN; else w_next = ST_SCAN;
      ST_DRAIN: w_next = ST_EMIT;
      ST_EMIT: begin
        if (!w_stat_valid) begin
          w_next = ST_DONE;
        end else if (stat_ready && w_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_EMIT;
        end
      end
      ST_DONE:  if (start) w_next = ST_SCAN; else w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, scan address, read pipeline tag, record index and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= (r_state == ST_SCAN);
      r_rd_addr  <= r_addr;
      if (w_start_ok) begin
        r_addr     <= '0;
        r_idx      <= '0;
        r_overflow <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        if ((r_state == ST_SCAN) && (r_addr != ADDR_LAST)) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
        if (w_stat_valid && stat_ready) begin
          r_idx <= r_idx + IDX_W'(1);
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if ((r_state == ST_EMIT) && (w_next == ST_DONE)) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign sram_a       = r_addr;
  assign sram_wen     = 1'b1;
  assign stat_valid   = w_stat_valid;
  assign stat_label   = w_stat_valid ? w_entry.label   : 8'd0;
  assign stat_count   = w_stat_valid ? w_entry.count   : CNT_W'(0);
  assign stat_row_min = w_stat_valid ? w_entry.row_min : POS_W'(0);
  assign stat_row_max = w_stat_valid ? w_entry.row_max : POS_W'(0);
  assign stat_col_min = w_stat_valid ? w_entry.col_min : POS_W'(0);
  assign stat_col_max = w_stat_valid ? w_entry.col_max : POS_W'(0);
  assign overflow     = r_overflow;
  assign done         = r_done;

endmodule

// File: tb/tb_cle_label_stat.sv
// Directed bench for cle_label_stat with a behavioural 1024x8 SRAM.
module tb_cle_label_stat;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic        sram_wen;
  logic        stat_valid;
  logic        stat_ready;
  logic [7:0]  stat_label;
  logic [10:0] stat_count;
  logic [4:0]  stat_row_min;
  logic [4:0]  stat_row_max;
  logic [4:0]  stat_col_min;
  logic [4:0]  stat_col_max;
  logic        overflow;
  logic        done;

  logic [7:0]  mem [1024];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          xfers;

  logic [7:0]  bp_lbl [3] = '{8'h21, 8'h22, 8'h23};
  logic [4:0]  bp_row [3] = '{5'd0, 5'd1, 5'd3};
  logic [4:0]  bp_col [3] = '{5'd5, 5'd8, 5'd4};
  int          bp_sel [6] = '{0, 0, 0, 1, 1, 2};
  logic [5:0]  bp_rdy     = 6'b110100;

  cle_label_stat #(.MAX_LABELS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sram_q       (sram_q),
    .sram_a       (sram_a),
    .sram_wen     (sram_wen),
    .stat_valid   (stat_valid),
    .stat_ready   (stat_ready),
    .stat_label   (stat_label),
    .stat_count   (stat_count),
    .stat_row_min (stat_row_min),
    .stat_row_max (stat_row_max),
    .stat_col_min (stat_col_min),
    .stat_col_max (stat_col_max),
    .overflow     (overflow),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_q <= mem[sram_a];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Start a scan and advance to the first EMIT cycle (T+1026).
  task automatic to_emit();
    pulse_start();
    tick(1025);
  endtask

  task automatic expect_rec(input string tag, input logic [7:0] l, input logic [10:0] c,
                            input logic [4:0] r0, input logic [4:0] r1,
                            input logic [4:0] c0, input logic [4:0] c1);
    chk({tag, ".valid"}, {31'd0, stat_valid}, 32'd1);
    chk({tag, ".label"}, {24'd0, stat_label}, {24'd0, l});
    chk({tag, ".count"}, {21'd0, stat_count}, {21'd0, c});
    chk({tag, ".rmin"},  {27'd0, stat_row_min}, {27'd0, r0});
    chk({tag, ".rmax"},  {27'd0, stat_row_max}, {27'd0, r1});
    chk({tag, ".cmin"},  {27'd0, stat_col_min}, {27'd0, c0});
    chk({tag, ".cmax"},  {27'd0, stat_col_max}, {27'd0, c1});
  endtask

  // Eight records for labels 0x11..0x18 at row 0 cols 0..7; optional start pulse mid-EMIT.
  task automatic check_nine(input string tag, input bit pulse_mid);
    for (int i = 0; i < 8; i++) begin
      expect_rec($sformatf("%s.rec%0d", tag, i), 8'h11 + 8'(i), 11'd1, 5'd0, 5'd0, 5'(i), 5'(i));
      chk($sformatf("%s.ovf%0d", tag, i), {31'd0, overflow}, 32'd1);
      if (pulse_mid && i == 3) start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    chk({tag, ".done"},  {31'd0, done}, 32'd1);
    chk({tag, ".valid"}, {31'd0, stat_valid}, 32'd0);
    chk({tag, ".ovf"},   {31'd0, overflow}, 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    stat_ready = 1'b0;
    clear_mem();
    tick(2);
    chk("rst.valid", {31'd0, stat_valid}, 32'd0);
    chk("rst.done",  {31'd0, done}, 32'd0);
    chk("rst.ovf",   {31'd0, overflow}, 32'd0);
    chk("rst.wen",   {31'd0, sram_wen}, 32'd1);
    chk("rst.addr",  {22'd0, sram_a}, 32'd0);
    chk("rst.count", {21'd0, stat_count}, 32'd0);
    reset = 1'b0;
    tick(1);

    // All-zero image: no records, done at T+1027.
    pulse_start();
    chk("zero.a0", {22'd0, sram_a}, 32'd0);
    tick(1);
    chk("zero.a1", {22'd0, sram_a}, 32'd1);
    tick(1022);
    chk("zero.alast", {22'd0, sram_a}, 32'd1023);
    tick(1);
    chk("zero.drain_a", {22'd0, sram_a}, 32'd1023);
    tick(1);
    chk("zero.emit_valid", {31'd0, stat_valid}, 32'd0);
    chk("zero.emit_done",  {31'd0, done}, 32'd0);
    tick(1);
    chk("zero.done",  {31'd0, done}, 32'd1);
    chk("zero.valid", {31'd0, stat_valid}, 32'd0);
    chk("zero.ovf",   {31'd0, overflow}, 32'd0);
    chk("zero.wen",   {31'd0, sram_wen}, 32'd1);

    // Single 3x4 block of label 0x05.
    for (int r = 2; r <= 4; r++)
      for (int c = 7; c <= 10; c++) mem[r*32 + c] = 8'h05;
    stat_ready = 1'b1;
    to_emit();
    chk("blk.done_pre", {31'd0, done}, 32'd0);
    expect_rec("blk", 8'h05, 11'd12, 5'd2, 5'd4, 5'd7, 5'd10);
    tick(1);
    chk("blk.done",  {31'd0, done}, 32'd1);
    chk("blk.valid", {31'd0, stat_valid}, 32'd0);
    chk("blk.ovf",   {31'd0, overflow}, 32'd0);

    // First and last pixel; the last one is only seen in DRAIN.
    clear_mem();
    mem[0]    = 8'h09;
    mem[1023] = 8'h03;
    to_emit();
    expect_rec("corner0", 8'h09, 11'd1, 5'd0, 5'd0, 5'd0, 5'd0);
    tick(1);
    expect_rec("corner1", 8'h03, 11'd1, 5'd31, 5'd31, 5'd31, 5'd31);
    chk("corner.done_mid", {31'd0, done}, 32'd0);
    tick(1);
    chk("corner.done",  {31'd0, done}, 32'd1);
    chk("corner.valid", {31'd0, stat_valid}, 32'd0);

    // Nine distinct labels: the ninth overflows the table.
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 8'h11 + 8'(i);
    to_emit();
    check_nine("ovf", 1'b0);

    // Backpressure with three labels.
    clear_mem();
    mem[5]   = 8'h21;
    mem[40]  = 8'h22;
    mem[100] = 8'h23;
    stat_ready = 1'b0;
    to_emit();
    xfers = 0;
    for (int c = 0; c < 6; c++) begin
      stat_ready = bp_rdy[c];
      expect_rec($sformatf("bp.c%0d", c), bp_lbl[bp_sel[c]], 11'd1,
                 bp_row[bp_sel[c]], bp_row[bp_sel[c]], bp_col[bp_sel[c]], bp_col[bp_sel[c]]);
      chk($sformatf("bp.done%0d", c), {31'd0, done}, 32'd0);
      if (stat_valid && stat_ready) xfers++;
      tick(1);
    end
    chk("bp.xfers", xfers, 32'd3);
    chk("bp.done",  {31'd0, done}, 32'd1);
    chk("bp.valid", {31'd0, stat_valid}, 32'd0);
    chk("bp.ovf",   {31'd0, overflow}, 32'd0);
    stat_ready = 1'b1;

    // Reset in the middle of a scan, then a clean rerun with a stray start during EMIT.
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 8'h11 + 8'(i);
    pulse_start();
    tick(500);
    chk("mid.addr", {22'd0, sram_a}, 32'd500);
    chk("mid.ovf",  {31'd0, overflow}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid.rst_addr",  {22'd0, sram_a}, 32'd0);
    chk("mid.rst_ovf",   {31'd0, overflow}, 32'd0);
    chk("mid.rst_done",  {31'd0, done}, 32'd0);
    chk("mid.rst_valid", {31'd0, stat_valid}, 32'd0);
    chk("mid.rst_wen",   {31'd0, sram_wen}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    chk("mid.idle_addr", {22'd0, sram_a}, 32'd0);
    chk("mid.idle_done", {31'd0, done}, 32'd0);
    to_emit();
    check_nine("rerun", 1'b1);
    tick(3);
    chk("rerun.hold_done", {31'd0, done}, 32'd1);
    chk("rerun.hold_addr", {22'd0, sram_a}, 32'd1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
